alu_seq: RTL and testbench

Multi-cycle issue/writeback sequencer that drives the existing 64-bit combinational `alu` and consumes its result. It accepts 16-bit instructions over a valid/ready handshake and decodes them into `a`/`b`/`op`. It reads operands from an internal 8-entry register file, captures `out` and writes it back. It sits between the instruction source (testbench or future fetch stage) and the ALU, and is the Lab 2 datapath core.

---
 rtl/alu_seq_pkg.sv | 50 +++++
 rtl/alu.sv | 26 ++
 rtl/alu_seq_rf.sv | 36 +++
 rtl/alu_seq.sv | 143 ++++++++++++++
 tb/tb_alu_seq.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants for the alu_seq sequencer: ALU op codes, instruction field
// layout, FSM state encoding and register-file size.
package alu_seq_pkg;

  localparam int NUM_REGS = 8;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_COM  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_ADDI = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 7;
  localparam int RT_MSB  = 6;
  localparam int RT_LSB  = 4;
  localparam int IMM_MSB = 6;
  localparam int IMM_LSB = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OPR  = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [6:0] imm7;
  } instr_fields_t;

  function automatic instr_fields_t decode(input logic [15:0] instr);
    instr_fields_t f;
    f.op   = instr[OP_MSB:OP_LSB];
    f.rd   = instr[RD_MSB:RD_LSB];
    f.rs   = instr[RS_MSB:RS_LSB];
    f.rt   = instr[RT_MSB:RT_LSB];
    f.imm7 = instr[IMM_MSB:IMM_LSB];
    return f;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational DSIZE-bit ALU; unknown op codes return zero.
module alu
  import alu_seq_pkg::*;
#(
  parameter int DSIZE = 64
) (
  input  logic [DSIZE-1:0] a,
  input  logic [DSIZE-1:0] b,
  input  logic [2:0]       op,
  output logic [DSIZE-1:0] out
);

  always_comb begin
    out = '0;
    case (op)
      OP_ADD, OP_ADDI: out = a + b;
      OP_SUB:          out = a - b;
      OP_AND:          out = a & b;
      OP_XOR:          out = a ^ b;
      OP_COM:          out = {{(DSIZE-1){1'b0}}, (a <= b)};
      OP_MUL:          out = a * b;
      default:         out = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq_rf.sv
// 8 x DSIZE register file: one synchronous write port, two internal and one
// debug combinational read port; r0 always reads zero.
module alu_seq_rf
  import alu_seq_pkg::*;
#(
  parameter int DSIZE = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [2:0]       waddr_i,
  input  logic [DSIZE-1:0] wdata_i,
  input  logic [2:0]       raddr_a_i,
  output logic [DSIZE-1:0] rdata_a_o,
  input  logic [2:0]       raddr_b_i,
  output logic [DSIZE-1:0] rdata_b_o,
  input  logic [2:0]       dbg_addr_i,
  output logic [DSIZE-1:0] dbg_data_o
);

  logic [DSIZE-1:0] regs_q [NUM_REGS];

  // Entry 0 is reset and never written, so it stays a constant zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != 3'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = regs_q[raddr_a_i];
  assign rdata_b_o  = regs_q[raddr_b_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_seq.sv
// Issue/writeback sequencer around the alu: IDLE -> OPR -> EXEC -> WB.
// Define ALU_SEQ_ILLEGAL_TRAP_EN to trap op 3'b111 and raise the sticky err flag.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int DSIZE       = 64,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [15:0]      instr,
  output logic             res_valid,
  output logic [DSIZE-1:0] res_data,
  output logic [2:0]       res_rd,
  output logic             err,
  output logic             busy,
  input  logic [2:0]       dbg_addr,
  output logic [DSIZE-1:0] dbg_data
);

  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  logic [1:0]       state_q, state_d;
  logic [15:0]      instr_q, instr_d;
  logic [DSIZE-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  instr_fields_t    f;
  logic [DSIZE-1:0] rs_data, rt_data, imm_ext, alu_out;
  logic             trap;

  assign f       = decode(instr_q);
  assign imm_ext = {{(DSIZE-7){f.imm7[6]}}, f.imm7};

  alu_seq_rf #(.DSIZE(DSIZE)) u_rf (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (res_valid),
    .waddr_i    (f.rd),
    .wdata_i    (res_q),
    .raddr_a_i  (f.rs),
    .rdata_a_o  (rs_data),
    .raddr_b_i  (f.rt),
    .rdata_b_o  (rt_data),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  alu #(.DSIZE(DSIZE)) u_alu (
    .a   (a_q),
    .b   (b_q),
    .op  (op_q),
    .out (alu_out)
  );

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  logic err_q, err_d;
  assign trap = (f.op == OP_ILL);
  assign err  = err_q;

  always_comb begin
    err_d = err_q;
    if (state_q == ST_OPR && trap) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`else
  assign trap = 1'b0;
  assign err  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_OPR;
        end
      end
      ST_OPR: begin
        if (trap) begin
          state_d = ST_IDLE;
        end else begin
          a_d     = rs_data;
          b_d     = (f.op == OP_ADDI) ? imm_ext : rt_data;
          op_d    = f.op;
          cnt_d   = CW'(EXEC_CYCLES - 1);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // ALU inputs are held from registers; sample only after the full hold time.
        if (cnt_q == '0) begin
          res_d   = alu_out;
          state_d = ST_WB;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign res_valid   = (state_q == ST_WB);
  assign res_data    = res_q;
  assign res_rd      = f.rd;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed plan plus random instructions checked
// against an architectural register-file model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int DSIZE = 64;
  localparam int EXEC  = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             instr_valid = 1'b0;
  logic [15:0]      instr = '0;
  logic [2:0]       dbg_addr = '0;
  logic             instr_ready, res_valid, err, busy;
  logic [DSIZE-1:0] res_data, dbg_data;
  logic [2:0]       res_rd;

  alu_seq #(.DSIZE(DSIZE), .EXEC_CYCLES(EXEC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_rd      (res_rd),
    .err         (err),
    .busy        (busy),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    logic [2:0]  rd;
    int          wb_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mreg [8];
  bit          merr;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs, input logic [2:0] rt);
    return {op, rd, rs, rt, 4'b0000};
  endfunction

  function automatic logic [15:0] mki(input logic [2:0] rd, input logic [2:0] rs,
                                      input logic [6:0] imm);
    return {OP_ADDI, rd, rs, imm};
  endfunction

  function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [63:0] a,
                                         input logic [63:0] b);
    case (op)
      OP_ADD, OP_ADDI: return a + b;
      OP_SUB:          return a - b;
      OP_AND:          return a & b;
      OP_XOR:          return a ^ b;
      OP_COM:          return (a <= b) ? 64'd1 : 64'd0;
      OP_MUL:          return a * b;
      default:         return 64'd0;
    endcase
  endfunction

  // Architectural effect of one accepted instruction; writeback due 2+EXEC later.
  task automatic model_accept(input logic [15:0] ins, input int c);
    logic [2:0]  op, rd, rs, rt;
    logic [6:0]  imm;
    logic [63:0] a, b, r;
    op  = ins[15:13];
    rd  = ins[12:10];
    rs  = ins[9:7];
    rt  = ins[6:4];
    imm = ins[6:0];
    a   = mreg[rs];
    b   = (op == OP_ADDI) ? {{57{imm[6]}}, imm} : mreg[rt];
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    if (op == 3'b111) begin
      merr = 1'b1;
      return;
    end
`endif
    r = ref_op(op, a, b);
    sb.push_back('{r, rd, c + 2 + EXEC});
    if (rd != 3'd0) mreg[rd] = r;
  endtask

  task automatic issue(input logic [15:0] ins, input bit keep, output int acc, output int lows);
    lows = 0;
    @(negedge clk);
    instr_valid = 1'b1;
    while (!instr_ready && lows < 100) begin
      instr = 16'($urandom);
      lows++;
      @(negedge clk);
    end
    if (!instr_ready) begin
      n_total++;
      $display("FAIL accept_timeout: instr_ready actual 0 required 1 within 100 cycles");
    end
    instr = ins;
    acc   = cyc;
    model_accept(ins, cyc);
    @(posedge clk);
    #1;
    if (!keep) instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || sb.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 64'(busy), 64'd0);
  endtask

  task automatic check_reg(input logic [2:0] idx, input logic [63:0] exp, input string name);
    dbg_addr = idx;
    #1;
    check(name, dbg_data, exp);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && res_valid) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_wb: actual res_valid rd=%0d data=%h required no writeback",
                   res_rd, res_data);
        end else begin
          e = sb.pop_front();
          $display("wb cyc=%0d rd=%0d data=%h", cyc, res_rd, res_data);
          check("wb_data", res_data, e.data);
          check("wb_rd", 64'(res_rd), 64'(e.rd));
          check("wb_cycle", 64'(cyc), 64'(e.wb_cyc));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int a1, a2, l1, l2;
    logic [2:0] op;
    for (int i = 0; i < 8; i++) mreg[i] = 64'd0;
    merr = 1'b0;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready", 64'(instr_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data", res_data, 64'd0);
    check("rst_res_rd", 64'(res_rd), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    for (int i = 0; i < 8; i++) check_reg(3'(i), 64'd0, "rst_reg");

    // ADDI r1,r0,5 with debug port watching r1 through the WB cycle
    dbg_addr = 3'd1;
    issue(mki(3'd1, 3'd0, 7'd5), 1'b0, a1, l1);
    @(negedge clk);
    repeat (EXEC + 1) @(negedge clk);
    check("wb_strobe", 64'(res_valid), 64'd1);
    check("dbg_old_in_wb", dbg_data, 64'd0);
    @(negedge clk);
    check("dbg_new_after_wb", dbg_data, 64'd5);
    check("idle_after_wb", 64'(busy), 64'd0);

    issue(mki(3'd2, 3'd0, 7'h7D), 1'b0, a1, l1);
    issue(mk(OP_MUL, 3'd3, 3'd1, 3'd2), 1'b0, a1, l1);
    issue(mk(OP_SUB, 3'd5, 3'd0, 3'd1), 1'b0, a1, l1);
    issue(mk(OP_COM, 3'd4, 3'd2, 3'd1), 1'b0, a1, l1);
    wait_idle();
    check_reg(3'd4, 64'd0, "com_unsigned_big_le_small");
    issue(mk(OP_COM, 3'd4, 3'd1, 3'd2), 1'b0, a1, l1);
    issue(mk(OP_XOR, 3'd6, 3'd1, 3'd1), 1'b0, a1, l1);
    issue(mk(OP_ADD, 3'd0, 3'd1, 3'd1), 1'b0, a1, l1);
    wait_idle();
    check_reg(3'd2, 64'hFFFF_FFFF_FFFF_FFFD, "addi_sext");
    check_reg(3'd3, 64'hFFFF_FFFF_FFFF_FFF1, "mul_low");
    check_reg(3'd5, 64'hFFFF_FFFF_FFFF_FFFB, "sub_wrap");
    check_reg(3'd4, 64'd1, "com_small_le_big");
    check_reg(3'd6, 64'd0, "xor_self");
    check_reg(3'd0, 64'd0, "r0_hardwired");

    // Back-to-back with instr_valid held high throughout
    issue(mk(OP_ADD, 3'd7, 3'd1, 3'd1), 1'b1, a1, l1);
    issue(mk(OP_SUB, 3'd6, 3'd3, 3'd1), 1'b1, a2, l2);
    instr_valid = 1'b0;
    check("b2b_accept_gap", 64'(a2 - a1), 64'(3 + EXEC));
    check("ready_low_cycles", 64'(l2), 64'(2 + EXEC));
    wait_idle();
    check_reg(3'd7, 64'd10, "b2b_first");
    check_reg(3'd6, 64'hFFFF_FFFF_FFFF_FFEC, "b2b_second");

    // Reset during EXEC aborts the instruction and clears the register file
    issue(mki(3'd7, 3'd0, 7'd9), 1'b0, a1, l1);
    sb.delete(sb.size() - 1);
    @(negedge clk);
    @(negedge clk);
    check("busy_in_exec", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) mreg[i] = 64'd0;
    merr = 1'b0;
    check("abort_idle", 64'(busy), 64'd0);
    repeat (EXEC + 4) @(negedge clk);
    check_reg(3'd7, 64'd0, "abort_r7");
    check_reg(3'd1, 64'd0, "abort_r1_cleared");

    // Op 3'b111: trapped or executed as zero depending on build
    issue(mki(3'd3, 3'd0, 7'd4), 1'b0, a1, l1);
    issue(mk(3'b111, 3'd3, 3'd3, 3'd3), 1'b0, a1, l1);
    wait_idle();
    check("illegal_err", 64'(err), 64'(merr));
    check_reg(3'd3, mreg[3], "illegal_rd");

    for (int k = 0; k < 40; k++) begin
      op = ($urandom_range(0, 9) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
      issue({op, 13'($urandom)}, 1'($urandom_range(0, 1)), a1, l1);
    end
    instr_valid = 1'b0;
    wait_idle();
    for (int i = 0; i < 8; i++) check_reg(3'(i), mreg[i], "rand_reg");
    check("rand_err", 64'(err), 64'(merr));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
